// File: rtl/ram_loader_if.sv
// ============================================================================
// Module      : ram_loader_if
// Description : Byte-stream, CPU-side and RAM-side signals of the ram_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_data_in;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data_in;
  logic                  ram_we;
  logic                  cpu_run;
  logic                  error;

  modport master (
    output in_data, in_valid, cpu_addr, cpu_data_in, cpu_we,
    input  in_ready, ram_addr, ram_data_in, ram_we, cpu_run, error
  );

  modport slave (
    input  in_data, in_valid, cpu_addr, cpu_data_in, cpu_we,
    output in_ready, ram_addr, ram_data_in, ram_we, cpu_run, error
  );
endinterface

`default_nettype wire

// File: rtl/ram_loader.sv
// ============================================================================
// Module      : ram_loader
// Description : Loads a length-prefixed byte stream into RAM, then hands the
//               RAM port to the CPU. RAM_LOADER_CHECKSUM_EN adds a checksum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  ram_loader_if.slave bus
);

  localparam int BPW   = DATA_WIDTH / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CNT_W-1:0] C_LAST_BYTE = CNT_W'(BPW - 1);

  typedef enum logic [2:0] {
    S_LEN_LO = 3'd0,
    S_LEN_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CHECK  = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  state_t                w_after_data;
  logic                  r_in_ready;
  logic [15:0]           r_len;
  logic [15:0]           r_words;
  logic [CNT_W-1:0]      r_byte_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_accept;
  logic                  w_word_done;

`ifdef RAM_LOADER_CHECKSUM_EN
  logic [7:0]            r_sum;
  assign w_after_data = S_CHECK;
`else
  assign w_after_data = S_DRAIN;
`endif

  assign w_accept      = bus.in_valid && r_in_ready;
  assign w_word_done   = (r_byte_cnt == C_LAST_BYTE);
  assign bus.in_ready  = r_in_ready;

  // Bytes enter at the top so the first byte of a word ends up in the LSBs.
  generate
    if (BPW == 1) begin : g_pack_single
      assign w_word = bus.in_data;
    end else begin : g_pack_multi
      assign w_word = {bus.in_data, r_shift[DATA_WIDTH-1:8]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_LEN_LO;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next == S_LEN_LO) || (w_state_next == S_LEN_HI) ||
                    (w_state_next == S_DATA)   || (w_state_next == S_CHECK);
    end
  end

  always_comb begin
    w_state_next    = r_state;
    bus.ram_addr    = r_wr_addr;
    bus.ram_data_in = r_wr_data;
    bus.ram_we      = r_we;
    bus.cpu_run     = 1'b0;
    bus.error       = 1'b0;
    case (r_state)
      S_LEN_LO: if (w_accept) w_state_next = S_LEN_HI;
      S_LEN_HI: if (w_accept)
        w_state_next = ({bus.in_data, r_len[7:0]} == 16'd0) ? w_after_data : S_DATA;
      S_DATA: if (w_accept && w_word_done && (r_words == r_len - 16'd1))
        w_state_next = w_after_data;
`ifdef RAM_LOADER_CHECKSUM_EN
      S_CHECK: if (w_accept)
        w_state_next = (bus.in_data == r_sum) ? S_DRAIN : S_ERROR;
      S_ERROR: begin
        bus.ram_we = 1'b0;
        bus.error  = 1'b1;
      end
`endif
      S_DRAIN: w_state_next = S_DONE;
      S_DONE: begin
        bus.ram_addr    = bus.cpu_addr;
        bus.ram_data_in = bus.cpu_data_in;
        bus.ram_we      = bus.cpu_we;
        bus.cpu_run     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_len      <= '0;
      r_words    <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_waddr    <= '0;
      r_we       <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
`ifdef RAM_LOADER_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      if (w_accept) begin
        case (r_state)
          S_LEN_LO: r_len[7:0]  <= bus.in_data;
          S_LEN_HI: r_len[15:8] <= bus.in_data;
          S_DATA: begin
`ifdef RAM_LOADER_CHECKSUM_EN
            r_sum <= r_sum + bus.in_data;
`endif
            r_shift <= w_word;
            if (w_word_done) begin
              r_byte_cnt <= '0;
              r_we       <= 1'b1;
              r_wr_addr  <= r_waddr;
              r_wr_data  <= w_word;
              r_waddr    <= r_waddr + 1'b1;
              r_words    <= r_words + 16'd1;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_loader.sv
// ============================================================================
// Module      : tb_ram_loader
// Description : Self-checking bench for ram_loader (wide and 2-bit address).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_loader;

  localparam int DW  = 32;
  localparam int BPW = DW / 8;
`ifdef RAM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  int            n_err   = 0;
  int            n_chk   = 0;
  logic [7:0]    stream[$];
  logic [DW-1:0] wq[$];

  always #5 clk = ~clk;

  ram_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(12)) ifa ();
  ram_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(2))  ifb ();

  assign ifb.in_data     = ifa.in_data;
  assign ifb.in_valid    = ifa.in_valid;
  assign ifb.cpu_addr    = ifa.cpu_addr[1:0];
  assign ifb.cpu_data_in = ifa.cpu_data_in;
  assign ifb.cpu_we      = ifa.cpu_we;

  ram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(12)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa.slave)
  );
  ram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    ifa.in_valid = 1'b0;
    ifa.cpu_we   = 1'b0;
    tick();
    chk("rst_ready",   64'(ifa.in_ready),    64'd0);
    chk("rst_we",      64'(ifa.ram_we),      64'd0);
    chk("rst_addr",    64'(ifa.ram_addr),    64'd0);
    chk("rst_data",    64'(ifa.ram_data_in), 64'd0);
    chk("rst_run",     64'(ifa.cpu_run),     64'd0);
    chk("rst_err",     64'(ifa.error),       64'd0);
    chk("rst_ready_b", 64'(ifb.in_ready),    64'd0);
    reset_n = 1'b1;
    chk("ready_hold",  64'(ifa.in_ready),    64'd0);
    tick();
    chk("ready_rise",  64'(ifa.in_ready),    64'd1);
  endtask

  // Stream = count lo/hi, words LSB first, optional modulo-256 payload sum.
  task automatic build_stream();
    int         n;
    logic [7:0] sum;
    n   = wq.size();
    sum = 8'd0;
    stream.delete();
    stream.push_back(n[7:0]);
    stream.push_back(n[15:8]);
    foreach (wq[i]) begin
      for (int k = 0; k < BPW; k++) begin
        stream.push_back(8'(wq[i] >> (8 * k)));
        sum = sum + 8'(wq[i] >> (8 * k));
      end
    end
    if (CSUM) stream.push_back(sum);
  endtask

  // mode 0: valid held high, 1: valid toggles, 2: random gaps. limit<0 = full stream.
  task automatic run_stream(input int mode, input int limit);
    int            n, plen, len, j, gaps;
    logic [7:0]    sum;
    logic [DW-1:0] w;
    bit            we_exp, exp_err;
    n    = int'(stream[0]) + 256 * int'(stream[1]);
    plen = n * BPW;
    len  = 2 + plen + (CSUM ? 1 : 0);
    sum  = 8'd0;
    for (int k = 0; k < plen; k++) sum = sum + stream[2 + k];
    exp_err = CSUM && (stream[len - 1] != sum);
    for (int i = 0; i < len && (limit < 0 || i < limit); i++) begin
      gaps = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
      for (int g = 0; g < gaps; g++) begin
        ifa.in_valid = 1'b0;
        ifa.in_data  = 8'($urandom);
        tick();
        chk("idle_we", 64'(ifa.ram_we), 64'd0);
      end
      ifa.in_valid = 1'b1;
      ifa.in_data  = stream[i];
      chk("ready_a", 64'(ifa.in_ready), 64'd1);
      chk("ready_b", 64'(ifb.in_ready), 64'd1);
      tick();
      ifa.in_valid = 1'b0;
      we_exp = (i >= 2) && (i < 2 + plen) && (((i - 2) % BPW) == BPW - 1);
      chk("we_a", 64'(ifa.ram_we), 64'(we_exp));
      chk("we_b", 64'(ifb.ram_we), 64'(we_exp));
      if (we_exp) begin
        j = (i - 2) / BPW;
        w = '0;
        for (int k = 0; k < BPW; k++) w = w | (DW'(stream[2 + j * BPW + k]) << (8 * k));
        chk("addr_a", 64'(ifa.ram_addr),    64'(j % 4096));
        chk("addr_b", 64'(ifb.ram_addr),    64'(j % 4));
        chk("data_a", 64'(ifa.ram_data_in), 64'(w));
        chk("data_b", 64'(ifb.ram_data_in), 64'(w));
      end
    end
    if (limit >= 0) return;
    if (exp_err) begin
      chk("err_flag",  64'(ifa.error),    64'd1);
      chk("err_run",   64'(ifa.cpu_run),  64'd0);
      chk("err_ready", 64'(ifa.in_ready), 64'd0);
      ifa.cpu_we      = 1'b1;
      ifa.cpu_addr    = 12'd5;
      ifa.cpu_data_in = DW'(32'hA5);
      tick();
      chk("err_block_we", 64'(ifa.ram_we), 64'd0);
      chk("err_sticky",   64'(ifa.error),  64'd1);
      ifa.cpu_we = 1'b0;
    end else begin
      chk("drain_run",   64'(ifa.cpu_run),  64'd0);
      chk("drain_ready", 64'(ifa.in_ready), 64'd0);
      chk("drain_err",   64'(ifa.error),    64'd0);
      tick();
      chk("done_run_a", 64'(ifa.cpu_run),  64'd1);
      chk("done_run_b", 64'(ifb.cpu_run),  64'd1);
      chk("done_ready", 64'(ifa.in_ready), 64'd0);
      chk("done_we0",   64'(ifa.ram_we),   64'd0);
      ifa.cpu_we      = 1'b1;
      ifa.cpu_addr    = 12'd5;
      ifa.cpu_data_in = DW'(32'hA5);
      #1;
      chk("fwd_we",     64'(ifa.ram_we),      64'd1);
      chk("fwd_addr",   64'(ifa.ram_addr),    64'd5);
      chk("fwd_data",   64'(ifa.ram_data_in), 64'hA5);
      chk("fwd_addr_b", 64'(ifb.ram_addr),    64'd1);
      ifa.cpu_we = 1'b0;
      #1;
      chk("fwd_we_off", 64'(ifa.ram_we), 64'd0);
    end
  endtask

  initial begin
    int n;
    ifa.in_data     = 8'd0;
    ifa.in_valid    = 1'b0;
    ifa.cpu_addr    = 12'd0;
    ifa.cpu_data_in = '0;
    ifa.cpu_we      = 1'b0;

    do_reset();
    wq = {32'h12345678, 32'hDEADBEEF};
    build_stream();
    run_stream(0, -1);

    do_reset();
    run_stream(1, -1);

    do_reset();
    wq.delete();
    build_stream();
    run_stream(0, -1);

    do_reset();
    wq = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    build_stream();
    run_stream(0, -1);

    do_reset();
    wq = {32'h12345678, 32'hDEADBEEF};
    build_stream();
    run_stream(0, 5);
    do_reset();
    run_stream(0, -1);

`ifdef RAM_LOADER_CHECKSUM_EN
    do_reset();
    wq = {32'h12345678, 32'hDEADBEEF};
    build_stream();
    stream[stream.size() - 1] = 8'h2F;
    run_stream(0, -1);
`endif

    for (int r = 0; r < 6; r++) begin
      do_reset();
      wq.delete();
      n = int'($urandom_range(0, 6));
      for (int k = 0; k < n; k++) wq.push_back(DW'($urandom));
      build_stream();
      run_stream(2, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
